button_debounce: RTL and testbench
==================================

# button_debounce

Upstream conditioning stage for the one-hot Moore sequencer: takes a raw, bouncing, asynchronous push-button and produces a clean single-cycle `en` pulse per accepted press. It synchronises the input, qualifies it with a stability counter and a four-state FSM, and also exports the debounced level. Its `en` output connects directly to the sequencer's `en` input, so each accepted press advances the sequencer exactly one state.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronised cycles needed to accept a press or release; legal range ≥ 2.
- `REPEAT_CYCLES`, 8: auto-repeat period in cycles; used only with `BUTTON_DEBOUNCE_AUTO_REPEAT_EN`; legal range ≥ 2.
- `clk`  input  1  sole clock; everything is sampled on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `btn_in`  input  1  raw button, asynchronous to `clk`, active-high.
- `en`  output  1  registered single-cycle press pulse, feeds the sequencer `en`.
- `btn_level`  output  1  registered debounced button level.

## Operation
- Synchroniser: two flops, `btn_in` → `s1` → `s2`. All logic uses `s2` only.
- Counter `cnt`:
  - width `$clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES))`;
  - cleared on every state transition;
  - never wraps.
- FSM states:
  - RELEASED:
    - `s2`=1 → PRESS_WAIT, `cnt`←0.
  - PRESS_WAIT:
    - `s2`=0 → RELEASED (bounce rejected, no pulse);
    - `s2`=1 and `cnt`==`DEBOUNCE_CYCLES`-1 → PRESSED, `en`←1;
    - otherwise `cnt`++.
  - PRESSED:
    - `s2`=0 → RELEASE_WAIT, `cnt`←0;
    - otherwise stay (auto-repeat counting only with the macro).
  - RELEASE_WAIT:
    - `s2`=1 → PRESSED (release bounce, no new pulse, `cnt`←0);
    - `s2`=0 and `cnt`==`DEBOUNCE_CYCLES`-1 → RELEASED;
    - otherwise `cnt`++.
- `en` is 1 only in the cycle after the edge that enters PRESSED from PRESS_WAIT, plus repeat pulses when enabled. It is never high for two consecutive cycles.
- `btn_level` is 1 exactly when the state is PRESSED or RELEASE_WAIT. It is registered alongside the state.
- Reset:
  - state←RELEASED; `s1`, `s2`, `cnt`, `en`, `btn_level`←0.
  - Reset has priority over every transition, including mid-count and mid-pulse.
  - A button held through reset deassertion is treated as a new press: full synchroniser plus debounce latency, then one pulse.

## Timing
- Edge 0 is the first rising edge that samples `btn_in`=1 (held stable thereafter).
  - `s2`=1 after edge 1.
  - PRESS_WAIT entered at edge 2.
  - PRESSED entered at edge `DEBOUNCE_CYCLES`+2.
  - `en`=1 and `btn_level`=1 for the cycle following that edge.
- Press latency: `DEBOUNCE_CYCLES`+2 edges. Release latency is the same, measured to `btn_level` falling.
- A bounce interval shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no output change.
- Minimum spacing between non-repeat pulses is 2·`DEBOUNCE_CYCLES`+2 cycles.

## Configuration
- Macro `BUTTON_DEBOUNCE_AUTO_REPEAT_EN`, when defined:
  - In PRESSED with `s2`=1, `cnt` increments each cycle.
  - When `cnt`==`REPEAT_CYCLES`-1, `en` pulses for one cycle and `cnt`←0.
  - First repeat pulse arrives `REPEAT_CYCLES` cycles after the initial pulse; subsequent pulses every `REPEAT_CYCLES` cycles.
  - Release (leaving PRESSED) stops repeats immediately. A return from RELEASE_WAIT restarts the period from 0.
- Macro undefined:
  - No repeat logic is compiled.
  - Exactly one `en` pulse per accepted press, regardless of hold time.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `REPEAT_CYCLES`=8.
- Clean press: `btn_in` 0→1 sampled at edge 0 and held → `en`=1 for exactly the cycle after edge 6; `btn_level`=1 from that cycle on; no further pulses (macro off).
- Bounce rejection: `btn_in` toggles high 2 cycles / low 2 cycles ×5, then stays 0 → `en` and `btn_level` remain 0 throughout.
- Release bounce: after an accepted press, `btn_in` goes low 2 cycles then high → `btn_level` stays 1 and no second `en`. A subsequent stable low → `btn_level` falls 6 edges after the first low sample.
- Reset mid-operation: assert `rst` for 1 cycle while in PRESS_WAIT with `cnt`=2, `btn_in` held high → outputs 0 during reset; after release exactly one `en` arrives 6 edges after the first post-reset sample.
- Auto-repeat (macro defined): hold `btn_in` high for 40 cycles → pulses after edges 6, 14, 22, 30, 38. Release → no further pulses.
- Sequencer hook-up: three clean presses into the sequencer's `en` → its `out` goes 0001→0010→0100→1000, one step per press.

Source files
------------

// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a
// four-state FSM. Emits a single-cycle `en` pulse per accepted press and the
// debounced level `btn_level`.
// Optional feature: define BUTTON_DEBOUNCE_AUTO_REPEAT_EN to emit repeat pulses
// every REPEAT_CYCLES cycles while the button stays pressed.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_CYCLES   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic en,
  output logic btn_level
);

  localparam int unsigned CntMax = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES
                                                                      : REPEAT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax);

  localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);
`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
  localparam logic [CntW-1:0] RepLast = CntW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    StReleased,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  logic            s1_d, s1_q;
  logic            s2_d, s2_q;
  state_e          state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            en_d, en_q;
  logic            btn_level_d, btn_level_q;

  // Synchroniser stages: only s2_q is ever looked at by the FSM.
  always_comb begin
    s1_d = btn_in;
    s2_d = s1_q;
  end

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    unique case (state_q)
      StReleased: begin
        if (s2_q) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end
      StPressWait: begin
        if (!s2_q) begin
          state_d = StReleased;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StPressed;
          cnt_d   = '0;
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPressed: begin
        if (!s2_q) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end
`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
        else if (cnt_q == RepLast) begin
          cnt_d = '0;
          en_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      StReleaseWait: begin
        if (s2_q) begin
          // Release bounce: back to pressed without a new pulse.
          state_d = StPressed;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StReleased;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StReleased;
        cnt_d   = '0;
      end
    endcase
    btn_level_d = (state_d == StPressed) || (state_d == StReleaseWait);
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      state_q     <= StReleased;
      cnt_q       <= '0;
      en_q        <= 1'b0;
      btn_level_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      btn_level_q <= btn_level_d;
    end
  end

  assign en        = en_q;
  assign btn_level = btn_level_q;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Each driven cycle pushes the outputs expected after the edge that samples it;
// the next falling edge pops and compares them against the DUT.
module tb_button_debounce;

  localparam int unsigned Deb = 4;
  localparam int unsigned Rep = 8;
`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
  localparam bit AutoRep = 1'b1;
  localparam int HoldLen = 40;
`else
  localparam bit AutoRep = 1'b0;
  localparam int HoldLen = 18;
`endif
  // Press/release latency in edges from the first sample of the new level.
  localparam int Lat = Deb + 2;

  typedef struct packed {
    logic en;
    logic lvl;
  } exp_t;

  logic clk;
  logic rst;
  logic btn_in;
  logic en;
  logic btn_level;

  exp_t       exp_q[$];
  string      cur_tag;
  int         n_vec;
  int         n_miscomp;
  logic [3:0] seq_out;

  button_debounce #(
    .DEBOUNCE_CYCLES(Deb),
    .REPEAT_CYCLES  (Rep)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .en       (en),
    .btn_level(btn_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] want);
    n_vec++;
    if (got !== want) begin
      n_miscomp++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Compare the outputs produced by the most recent edge.
  task automatic compare_pending();
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({cur_tag, ".en"}, {3'b0, en}, {3'b0, e.en});
      check({cur_tag, ".lvl"}, {3'b0, btn_level}, {3'b0, e.lvl});
      // Stand-in for the downstream one-hot sequencer stepping on en.
      if (en === 1'b1) seq_out = {seq_out[2:0], seq_out[3]};
    end
  endtask

  task automatic drive(input logic b, input logic r, input logic e_en, input logic e_lvl);
    exp_t e;
    @(negedge clk);
    compare_pending();
    btn_in = b;
    rst    = r;
    e.en   = e_en;
    e.lvl  = e_lvl;
    exp_q.push_back(e);
  endtask

  function automatic logic press_en(input int i);
    return (i == Lat) || (AutoRep && (i > Lat) && (((i - Lat) % Rep) == 0));
  endfunction

  // Stable high starting from released: pulse at Lat, level high from Lat on.
  task automatic press(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, press_en(i), i >= Lat);
  endtask

  // Stable low starting from pressed: level drops Lat edges after first low sample.
  task automatic release_btn(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, i < Lat);
  endtask

  initial begin
    n_vec     = 0;
    n_miscomp = 0;
    seq_out   = 4'b0001;
    rst       = 1'b1;
    btn_in    = 1'b0;

    cur_tag = "reset";
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);

    cur_tag = "clean_press";
    press(HoldLen);
    cur_tag = "clean_release";
    release_btn(10);

    // Two-cycle glitches never reach the debounce threshold.
    cur_tag = "bounce";
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);

    cur_tag = "rb_press";
    press(18);
    cur_tag = "rb_glitch";
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, 1'b1);
    cur_tag = "rb_release";
    release_btn(10);

    // Button held; reset lands in PRESS_WAIT with cnt=2, then a fresh press.
    cur_tag = "rst_mid";
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    cur_tag = "rst_repress";
    press(12);
    cur_tag = "rst_release";
    release_btn(10);

    cur_tag = "seq";
    seq_out = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      press(10);
      release_btn(10);
    end
    @(negedge clk);
    compare_pending();
    check("seq_out", seq_out, 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
    $finish;
  end

endmodule
